// File: rtl/keypad_decoder.sv
// Keypad decoder: debounces one key from the column scanner,
// first key wins, emits a 1-cycle strobe and the key's hex code.
module keypad_decoder #(
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rowsSync,
  input  logic [3:0] colsSync,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held
);

  localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [CW-1:0] MAXC = CW'(DEBOUNCE_FRAMES);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    DEB_PRESS,
    HELD,
    DEB_REL
  } state_t;

  state_t        state, state_n;
  logic [1:0]    r, r_n;
  logic [1:0]    c, c_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic          valid_n;
  logic [3:0]    code_n;
  logic          held_n;

  logic          sample;
  logic [1:0]    col_idx;
  logic [1:0]    row_low;
  logic          match;
  logic          miss;

  function automatic logic [3:0] keymap(
    input logic [1:0] rr,
    input logic [1:0] cc
  );
    logic [3:0] k;
    case ({rr, cc})
      4'b00_00: k = 4'h1;
      4'b00_01: k = 4'h2;
      4'b00_10: k = 4'h3;
      4'b00_11: k = 4'hA;
      4'b01_00: k = 4'h4;
      4'b01_01: k = 4'h5;
      4'b01_10: k = 4'h6;
      4'b01_11: k = 4'hB;
      4'b10_00: k = 4'h7;
      4'b10_01: k = 4'h8;
      4'b10_10: k = 4'h9;
      4'b10_11: k = 4'hC;
      4'b11_00: k = 4'hE;
      4'b11_01: k = 4'h0;
      4'b11_10: k = 4'hF;
      default:  k = 4'hD;
    endcase
    return k;
  endfunction

  // Only a single driven column counts as a sample.
  always_comb begin
    sample = (colsSync != 4'd0) &&
             ((colsSync & (colsSync - 4'd1)) == 4'd0);
  end

  always_comb begin
    case (colsSync)
      4'b0010: col_idx = 2'd1;
      4'b0100: col_idx = 2'd2;
      4'b1000: col_idx = 2'd3;
      default: col_idx = 2'd0;
    endcase
  end

  always_comb begin
    casez (rowsSync)
      4'b???1: row_low = 2'd0;
      4'b??10: row_low = 2'd1;
      4'b?100: row_low = 2'd2;
      default: row_low = 2'd3;
    endcase
  end

  always_comb begin
    match   = sample && colsSync[c] && rowsSync[r];
    miss    = sample && colsSync[c] && !rowsSync[r];
    cnt_inc = (cnt < MAXC) ? cnt + ONE : cnt;
  end

  always_comb begin
    state_n = state;
    r_n     = r;
    c_n     = c;
    cnt_n   = cnt;
    valid_n = 1'b0;
    code_n  = key_code;
    held_n  = key_held;
    unique case (state)
      IDLE: begin
        if (sample && rowsSync != 4'd0) begin
          c_n     = col_idx;
          r_n     = row_low;
          cnt_n   = ONE;
          state_n = DEB_PRESS;
        end
      end
      DEB_PRESS: begin
        if (match) begin
          cnt_n = cnt_inc;
          if (cnt_inc == MAXC) begin
            state_n = HELD;
            code_n  = keymap(r, c);
            valid_n = 1'b1;
            held_n  = 1'b1;
          end
        end else if (miss) begin
          state_n = IDLE;
        end
      end
      HELD: begin
        held_n = 1'b1;
        if (miss) begin
          cnt_n   = ONE;
          state_n = DEB_REL;
        end
      end
      DEB_REL: begin
        if (match) begin
          state_n = HELD;
        end else if (miss) begin
          cnt_n = cnt_inc;
          if (cnt_inc == MAXC) begin
            state_n = IDLE;
            held_n  = 1'b0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      r         <= 2'd0;
      c         <= 2'd0;
      cnt       <= '0;
      key_valid <= 1'b0;
      key_code  <= 4'h0;
      key_held  <= 1'b0;
    end else begin
      state     <= state_n;
      r         <= r_n;
      c         <= c_n;
      cnt       <= cnt_n;
      key_valid <= valid_n;
      key_code  <= code_n;
      key_held  <= held_n;
    end
  end

endmodule

// File: tb/tb_keypad_decoder.sv
// Directed bench for keypad_decoder with a rotating
// column scanner model (1000->0100->0010->0001).
module tb_keypad_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] rowsSync = 4'd0;
  logic [3:0] colsSync = 4'd0;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_held;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int pulses = 0;
  int pulse_cyc = -1;
  int falls = 0;
  int fall_cyc = -1;
  int colidx = 3;
  int t;
  logic prev_held = 1'b0;
  logic blank = 1'b0;
  logic [3:0] keys [4];

  keypad_decoder #(.DEBOUNCE_FRAMES(4)) dut (
    .clk(clk),
    .reset(reset),
    .rowsSync(rowsSync),
    .colsSync(colsSync),
    .key_valid(key_valid),
    .key_code(key_code),
    .key_held(key_held)
  );

  always #5 clk = ~clk;

  // One scanner cycle; cyc is the cycle the outputs belong to.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      if (blank) begin
        colsSync = 4'b0000;
        rowsSync = 4'b1111;
      end else begin
        colsSync = 4'b0001 << colidx;
        rowsSync = keys[colidx];
        colidx = (colidx + 3) % 4;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (key_valid === 1'b1) begin
        pulses++;
        pulse_cyc = cyc;
      end
      if (prev_held === 1'b1 && key_held === 1'b0) begin
        falls++;
        fall_cyc = cyc;
      end
      prev_held = key_held;
    end
  endtask

  task automatic align(input int col);
    for (int i = 0; i < 4 && colidx != col; i++) tick(1);
  endtask

  task automatic clr();
    pulses = 0;
    pulse_cyc = -1;
    falls = 0;
    fall_cyc = -1;
  endtask

  task automatic release_all();
    for (int i = 0; i < 4; i++) keys[i] = 4'd0;
    tick(20);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) keys[i] = 4'd0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (key_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_valid: got %b expected 0", key_valid);
    end
    vectors++;
    if (key_code !== 4'h0) begin
      miscompares++;
      $display("FAIL rst_code: got %h expected 0", key_code);
    end
    vectors++;
    if (key_held !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_held: got %b expected 0", key_held);
    end
    reset = 1'b0;
  endtask

  task automatic test_press();
    align(1);
    clr();
    keys[1] = 4'b0010;
    t = cyc;
    tick(16);
    vectors++;
    if (pulses != 1) begin
      miscompares++;
      $display("FAIL press_pulses: got %0d expected 1", pulses);
    end
    vectors++;
    if (pulse_cyc != t + 13) begin
      miscompares++;
      $display("FAIL press_latency: got %0d expected %0d", pulse_cyc, t + 13);
    end
    vectors++;
    if (key_code !== 4'h5) begin
      miscompares++;
      $display("FAIL press_code: got %h expected 5", key_code);
    end
    vectors++;
    if (key_held !== 1'b1) begin
      miscompares++;
      $display("FAIL press_held: got %b expected 1", key_held);
    end
    align(1);
    clr();
    keys[1] = 4'd0;
    t = cyc;
    tick(16);
    vectors++;
    if (fall_cyc != t + 13) begin
      miscompares++;
      $display("FAIL release_cyc: got %0d expected %0d", fall_cyc, t + 13);
    end
    vectors++;
    if (key_held !== 1'b0 || pulses != 0) begin
      miscompares++;
      $display("FAIL release_state: got held=%b pulses=%0d expected 0/0",
               key_held, pulses);
    end
  endtask

  task automatic test_bounce();
    align(1);
    clr();
    keys[1] = 4'b0010;
    tick(5);
    keys[1] = 4'd0;
    tick(12);
    vectors++;
    if (pulses != 0 || key_held !== 1'b0) begin
      miscompares++;
      $display("FAIL bounce_nostrobe: got pulses=%0d held=%b expected 0/0",
               pulses, key_held);
    end
    vectors++;
    if (key_code !== 4'h5) begin
      miscompares++;
      $display("FAIL bounce_code: got %h expected 5", key_code);
    end
    align(1);
    clr();
    keys[1] = 4'b0010;
    t = cyc;
    tick(16);
    vectors++;
    if (pulses != 1 || pulse_cyc != t + 13) begin
      miscompares++;
      $display("FAIL bounce_fresh: got pulses=%0d at %0d expected 1 at %0d",
               pulses, pulse_cyc, t + 13);
    end
    release_all();
  endtask

  task automatic test_first_key_wins();
    align(1);
    keys[1] = 4'b0010;
    tick(16);
    clr();
    keys[2] = 4'b0100;
    tick(16);
    vectors++;
    if (pulses != 0 || key_code !== 4'h5 || key_held !== 1'b1) begin
      miscompares++;
      $display("FAIL fkw_ignore: got pulses=%0d code=%h held=%b expected 0/5/1",
               pulses, key_code, key_held);
    end
    align(1);
    clr();
    keys[1] = 4'd0;
    t = cyc;
    tick(32);
    vectors++;
    if (fall_cyc != t + 13) begin
      miscompares++;
      $display("FAIL fkw_release: got %0d expected %0d", fall_cyc, t + 13);
    end
    vectors++;
    if (pulses != 1 || pulse_cyc != t + 28) begin
      miscompares++;
      $display("FAIL fkw_second: got pulses=%0d at %0d expected 1 at %0d",
               pulses, pulse_cyc, t + 28);
    end
    vectors++;
    if (key_code !== 4'h9 || key_held !== 1'b1) begin
      miscompares++;
      $display("FAIL fkw_code: got code=%h held=%b expected 9/1",
               key_code, key_held);
    end
    release_all();
  endtask

  task automatic test_multi_row();
    align(3);
    clr();
    keys[3] = 4'b0101;
    t = cyc;
    tick(16);
    vectors++;
    if (pulses != 1 || pulse_cyc != t + 13) begin
      miscompares++;
      $display("FAIL multirow_pulse: got %0d at %0d expected 1 at %0d",
               pulses, pulse_cyc, t + 13);
    end
    vectors++;
    if (key_code !== 4'hA) begin
      miscompares++;
      $display("FAIL multirow_code: got %h expected A", key_code);
    end
    release_all();
  endtask

  task automatic test_glitch();
    align(1);
    keys[1] = 4'b0010;
    tick(16);
    align(1);
    clr();
    keys[1] = 4'd0;
    tick(1);
    keys[1] = 4'b0010;
    tick(15);
    vectors++;
    if (falls != 0 || key_held !== 1'b1) begin
      miscompares++;
      $display("FAIL glitch_held: got falls=%0d held=%b expected 0/1",
               falls, key_held);
    end
    vectors++;
    if (pulses != 0) begin
      miscompares++;
      $display("FAIL glitch_strobe: got %0d expected 0", pulses);
    end
    release_all();
    clr();
    blank = 1'b1;
    tick(10);
    blank = 1'b0;
    vectors++;
    if (pulses != 0 || key_held !== 1'b0) begin
      miscompares++;
      $display("FAIL blank_idle: got pulses=%0d held=%b expected 0/0",
               pulses, key_held);
    end
    align(1);
    clr();
    keys[1] = 4'b0010;
    t = cyc;
    tick(16);
    vectors++;
    if (pulses != 1 || pulse_cyc != t + 13) begin
      miscompares++;
      $display("FAIL blank_after: got %0d at %0d expected 1 at %0d",
               pulses, pulse_cyc, t + 13);
    end
    release_all();
  endtask

  task automatic test_reset_mid();
    align(1);
    keys[1] = 4'b0010;
    tick(9);
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if (key_valid !== 1'b0 || key_held !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_flags: got valid=%b held=%b expected 0/0",
               key_valid, key_held);
    end
    vectors++;
    if (key_code !== 4'h0) begin
      miscompares++;
      $display("FAIL midrst_code: got %h expected 0", key_code);
    end
    tick(2);
    reset = 1'b0;
    clr();
    align(1);
    t = cyc;
    tick(16);
    vectors++;
    if (pulses != 1 || pulse_cyc != t + 13) begin
      miscompares++;
      $display("FAIL midrst_fresh: got %0d at %0d expected 1 at %0d",
               pulses, pulse_cyc, t + 13);
    end
    vectors++;
    if (key_code !== 4'h5) begin
      miscompares++;
      $display("FAIL midrst_code2: got %h expected 5", key_code);
    end
    release_all();
  endtask

  initial begin
    test_reset();
    test_press();
    test_bounce();
    test_first_key_wins();
    test_multi_row();
    test_glitch();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
